// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side character buffer placed directly after a UART
//               receiver. Each rising edge of rx_ready captures one rx_data
//               character into a DEPTH-entry FIFO. Characters are presented
//               first-word-fall-through with a valid/ack pop handshake.
//               Characters that arrive while the FIFO is full (and not being
//               popped in the same cycle) are dropped, flagged and counted.
// Ports       :
//   clk         in   1            system clock, posedge
//   rst         in   1            synchronous active-high reset
//   rx_data     in   DATA_WIDTH   character from receiver
//   rx_ready    in   1            receiver character-complete level
//   out_data    out  DATA_WIDTH   head-of-FIFO character (valid with out_valid)
//   out_valid   out  1            FIFO non-empty
//   out_ack     in   1            consumer pop, ignored while empty
//   count       out  CNT_W        occupancy, 0..DEPTH
//   overflow    out  1            sticky drop flag
//   clear_ovf   in   1            clears overflow and drop_count
//   drop_count  out  8            dropped characters, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       rx_data,
    input  logic                        rx_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ack,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    input  logic                        clear_ovf,
    output logic [7:0]                  drop_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [7:0]         c_DROP_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rx_ready_q;
    logic [c_PTR_W-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q,      count_d;
    logic                  overflow_q,   overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // One request per rising edge of rx_ready; a long stop-bit level is a
    // single character.
    assign w_push_req = rx_ready & ~rx_ready_q;
    assign w_full     = (count_q == c_FULL_CNT);
    assign w_pop      = out_valid & out_ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as clear_ovf wins: the clear empties the
        // history and the new drop is the first one counted afterwards.
        if (w_drop) begin
            overflow_d = 1'b1;
            if (clear_ovf) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != c_DROP_MAX) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (clear_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Held high so a receiver already asserting rx_ready when reset
            // releases is not mistaken for a new character.
            rx_ready_q   <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            rx_ready_q   <= rx_ready;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage (not reset). When full with a simultaneous pop, wr_ptr equals
    // rd_ptr; the head is read combinationally this cycle before the slot is
    // overwritten at the edge, so no data is lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registers only.
    // ------------------------------------------------------------------------
    assign out_data   = mem[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo (DEPTH=16,
//               DATA_WIDTH=7). Inputs change 1 time unit after posedge,
//               outputs are sampled on the following negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH      = 16;
    localparam int DATA_WIDTH = 7;

    logic                  clk;
    logic                  rst;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ack;
    logic [4:0]            count;
    logic                  overflow;
    logic                  clear_ovf;
    logic [7:0]            drop_count;

    int n_tests;
    int n_fail;

    uart_rx_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .count      (count),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs may be changed right after returning.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the negedge of the current cycle for sampling, then back to
    // the drive point after the next posedge is handled by the caller.
    task automatic sample_point();
        @(negedge clk);
    endtask

    // One receiver character: rising edge of rx_ready then low for a cycle.
    task automatic push_char(input logic [DATA_WIDTH-1:0] d);
        rx_data  = d;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rx_data   = '0;
        rx_ready  = 1'b0;
        out_ack   = 1'b0;
        clear_ovf = 1'b0;

        tick();
        tick();
        sample_point();
        check("rst_count",    32'(count),      32'd0);
        check("rst_valid",    32'(out_valid),  32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_drop",     32'(drop_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();                 // rx_ready low for one edge after reset

        // ---- long rx_ready level gives exactly one capture ----------------
        rx_data  = 7'h41;
        rx_ready = 1'b1;
        tick();
        sample_point();
        check("lvl_count1", 32'(count),     32'd1);
        check("lvl_valid",  32'(out_valid), 32'd1);
        check("lvl_data",   32'(out_data),  32'h41);
        for (int i = 0; i < 19; i++) tick();
        sample_point();
        check("lvl_count_held", 32'(count), 32'd1);
        tick();
        rx_ready = 1'b0;
        out_ack  = 1'b1;
        tick();
        out_ack  = 1'b0;
        sample_point();
        check("lvl_popped", 32'(count), 32'd0);
        tick();

        // ---- three characters drained back to back ------------------------
        push_char(7'h01);
        push_char(7'h02);
        push_char(7'h03);
        out_ack = 1'b1;
        sample_point();
        check("seq_d0", 32'(out_data), 32'h01);
        tick();
        sample_point();
        check("seq_d1", 32'(out_data), 32'h02);
        tick();
        sample_point();
        check("seq_d2", 32'(out_data), 32'h03);
        tick();
        sample_point();
        check("seq_empty_valid", 32'(out_valid), 32'd0);
        check("seq_empty_count", 32'(count),     32'd0);
        tick();                 // ack held while empty
        sample_point();
        check("underflow_count", 32'(count), 32'd0);
        tick();
        out_ack = 1'b0;

        // ---- 17 characters into 16 entries --------------------------------
        for (int i = 0; i < 17; i++) push_char(7'(8'h10 + i));
        sample_point();
        check("ovf_count",    32'(count),      32'd16);
        check("ovf_flag",     32'(overflow),   32'd1);
        check("ovf_drop",     32'(drop_count), 32'd1);
        tick();
        out_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sample_point();
            check($sformatf("ovf_drain%0d", i), 32'(out_data), 32'(8'h10 + i));
            tick();
        end
        out_ack = 1'b0;
        sample_point();
        check("ovf_drained", 32'(out_valid), 32'd0);
        tick();

        // ---- drop_count to 3, clear, then clear coincident with a drop ----
        for (int i = 0; i < 18; i++) push_char(7'(8'h20 + i));
        sample_point();
        check("clr_drop3", 32'(drop_count), 32'd3);
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        sample_point();
        check("clr_ovf0",  32'(overflow),   32'd0);
        check("clr_drop0", 32'(drop_count), 32'd0);
        tick();
        push_char(7'h55);       // dropped: drop_count becomes 1
        rx_data   = 7'h56;
        rx_ready  = 1'b1;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        rx_ready  = 1'b0;
        sample_point();
        check("coin_ovf",   32'(overflow),   32'd1);
        check("coin_drop",  32'(drop_count), 32'd1);
        check("coin_count", 32'(count),      32'd16);
        tick();

        // ---- full FIFO with simultaneous push and pop ---------------------
        rx_data  = 7'h3A;
        rx_ready = 1'b1;
        out_ack  = 1'b1;
        sample_point();
        check("fp_head", 32'(out_data), 32'h20);
        tick();
        rx_ready = 1'b0;
        out_ack  = 1'b0;
        sample_point();
        check("fp_count", 32'(count),      32'd16);
        check("fp_drop",  32'(drop_count), 32'd1);
        tick();
        out_ack = 1'b1;
        for (int i = 1; i < 16; i++) begin
            sample_point();
            check($sformatf("fp_drain%0d", i), 32'(out_data), 32'(8'h20 + i));
            tick();
        end
        sample_point();
        check("fp_last", 32'(out_data), 32'h3A);
        tick();
        out_ack = 1'b0;
        sample_point();
        check("fp_empty", 32'(out_valid), 32'd0);
        tick();

        // ---- reset while rx_ready high and 5 entries stored ---------------
        for (int i = 0; i < 5; i++) push_char(7'(8'h60 + i));
        sample_point();
        check("mid_count5", 32'(count), 32'd5);
        tick();
        rx_data  = 7'h66;
        rx_ready = 1'b1;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        sample_point();
        check("mid_count0", 32'(count),     32'd0);
        check("mid_valid0", 32'(out_valid), 32'd0);
        tick();
        rx_ready = 1'b0;
        tick();
        rx_data  = 7'h77;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        sample_point();
        check("mid_recap_count", 32'(count),    32'd1);
        check("mid_recap_data",  32'(out_data), 32'h77);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
